// File: rtl/rat_int.sv
// Integer register alias table: renames up to RENAME_WIDTH instructions per
// cycle with intra-group bypass and CP_INDEX_SIZE-bit checkpoint/recover.
module rat_int #(
  parameter int RENAME_WIDTH       = 3,
  parameter int ARF_INDEX_SIZE     = 5,
  parameter int PRF_INT_INDEX_SIZE = 6,
  parameter int CP_INDEX_SIZE      = 2
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [RENAME_WIDTH-1:0]                          rename_valid,
  input  logic [RENAME_WIDTH-1:0]                          rd_valid,
  input  logic [RENAME_WIDTH-1:0][ARF_INDEX_SIZE-1:0]      rs1,
  input  logic [RENAME_WIDTH-1:0][ARF_INDEX_SIZE-1:0]      rs2,
  input  logic [RENAME_WIDTH-1:0][ARF_INDEX_SIZE-1:0]      rd,
  input  logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  prf_in,
  input  logic                                             allocatable,
  input  logic                                             check,
  input  logic [CP_INDEX_SIZE-1:0]                         check_idx,
  input  logic                                             recover,
  input  logic [CP_INDEX_SIZE-1:0]                         recover_idx,
  output logic [RENAME_WIDTH-1:0]                          prf_req,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  prs1_out,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  prs2_out,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  prd_out,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  prd_old_out,
  output logic [RENAME_WIDTH-1:0]                          out_valid
);

  localparam int NumArf = 2 ** ARF_INDEX_SIZE;
  localparam int NumCp  = 2 ** CP_INDEX_SIZE;
  localparam int P      = PRF_INT_INDEX_SIZE;

  logic [P-1:0] map_q [NumArf];
  logic [P-1:0] map_d [NumArf];
  logic [P-1:0] cp_q  [NumCp][NumArf];

  logic                                 fire;
  logic [RENAME_WIDTH-1:0]              w;
  logic [RENAME_WIDTH-1:0]              out_valid_d, out_valid_q;
  logic [RENAME_WIDTH-1:0][P-1:0]       prs1_d, prs1_q, prs2_d, prs2_q;
  logic [RENAME_WIDTH-1:0][P-1:0]       prd_d, prd_q, prd_old_d, prd_old_q;
  logic [P-1:0]                         s1, s2, so;

  always_comb begin
    fire        = allocatable & ~recover;
    prf_req     = '0;
    w           = '0;
    prs1_d      = '0;
    prs2_d      = '0;
    prd_d       = '0;
    prd_old_d   = '0;
    out_valid_d = fire ? rename_valid : '0;
    s1          = '0;
    s2          = '0;
    so          = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      prf_req[i] = rename_valid[i] & rd_valid[i] & (rd[i] != '0) & ~recover;
      w[i]       = fire & prf_req[i];
    end
    // Lookups see the table plus writes from older lanes; later lanes win.
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      s1 = map_q[rs1[i]];
      s2 = map_q[rs2[i]];
      so = map_q[rd[i]];
      for (int j = 0; j < RENAME_WIDTH; j++) begin
        if (j < i && w[j]) begin
          if (rd[j] == rs1[i]) s1 = prf_in[j];
          if (rd[j] == rs2[i]) s2 = prf_in[j];
          if (rd[j] == rd[i])  so = prf_in[j];
        end
      end
      if (rs1[i] == '0) s1 = '0;
      if (rs2[i] == '0) s2 = '0;
      if (out_valid_d[i]) begin
        prs1_d[i] = s1;
        prs2_d[i] = s2;
      end
      if (w[i]) begin
        prd_d[i]     = prf_in[i];
        prd_old_d[i] = so;
      end
    end
    for (int r = 0; r < NumArf; r++) begin
      map_d[r] = recover ? cp_q[recover_idx][r] : map_q[r];
    end
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      if (w[i]) map_d[rd[i]] = prf_in[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NumArf; r++) begin
        map_q[r] <= P'(r);
        for (int k = 0; k < NumCp; k++) cp_q[k][r] <= P'(r);
      end
      out_valid_q <= '0;
      prs1_q      <= '0;
      prs2_q      <= '0;
      prd_q       <= '0;
      prd_old_q   <= '0;
    end else begin
      for (int r = 0; r < NumArf; r++) begin
        map_q[r] <= map_d[r];
        if (check && !recover) cp_q[check_idx][r] <= map_d[r];
      end
      out_valid_q <= out_valid_d;
      prs1_q      <= prs1_d;
      prs2_q      <= prs2_d;
      prd_q       <= prd_d;
      prd_old_q   <= prd_old_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign prs1_out    = prs1_q;
  assign prs2_out    = prs2_q;
  assign prd_out     = prd_q;
  assign prd_old_out = prd_old_q;

endmodule

// File: tb/tb_rat_int.sv
// Directed, table-driven bench for rat_int: rename, bypass, x0, stall,
// checkpoint/recover priority and asynchronous reset.
module tb_rat_int;

  logic              clock;
  logic              reset;
  logic [2:0]        rename_valid, rd_valid;
  logic [2:0][4:0]   rs1, rs2, rd;
  logic [2:0][5:0]   prf_in;
  logic              allocatable, check, recover;
  logic [1:0]        check_idx, recover_idx;
  logic [2:0]        prf_req, out_valid;
  logic [2:0][5:0]   prs1_out, prs2_out, prd_out, prd_old_out;

  int vecCount;
  int missCount;

  rat_int dut (
    .clock(clock), .reset(reset),
    .rename_valid(rename_valid), .rd_valid(rd_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .prf_in(prf_in),
    .allocatable(allocatable),
    .check(check), .check_idx(check_idx),
    .recover(recover), .recover_idx(recover_idx),
    .prf_req(prf_req), .prs1_out(prs1_out), .prs2_out(prs2_out),
    .prd_out(prd_out), .prd_old_out(prd_old_out), .out_valid(out_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [2:0]      rv, rdv;
    logic [2:0][4:0] s1, s2, d;
    logic [2:0][5:0] pin;
    logic            alloc, chk;
    logic [1:0]      chkIdx;
    logic            rec;
    logic [1:0]      recIdx;
    logic [2:0]      expReq, expOv;
    logic [2:0][5:0] expPrs1, expPrs2, expPrd, expPrdOld;
  } vec_t;

  localparam int NumVec = 15;
  vec_t vecs [NumVec];

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, idx, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rename_valid = v.rv;
    rd_valid     = v.rdv;
    rs1          = v.s1;
    rs2          = v.s2;
    rd           = v.d;
    prf_in       = v.pin;
    allocatable  = v.alloc;
    check        = v.chk;
    check_idx    = v.chkIdx;
    recover      = v.rec;
    recover_idx  = v.recIdx;
  endtask

  task automatic idleInputs();
    rename_valid = '0; rd_valid = '0; rs1 = '0; rs2 = '0; rd = '0; prf_in = '0;
    allocatable = 1'b1; check = 1'b0; check_idx = '0; recover = 1'b0; recover_idx = '0;
  endtask

  task automatic checkRegs(input string tag, input int idx, input logic [2:0] ov,
                           input logic [17:0] p1, input logic [17:0] p2,
                           input logic [17:0] pd, input logic [17:0] po);
    checkOutput({tag, " out_valid"}, idx, 32'(out_valid), 32'(ov));
    checkOutput({tag, " prs1"}, idx, 32'(prs1_out), 32'(p1));
    checkOutput({tag, " prs2"}, idx, 32'(prs2_out), 32'(p2));
    checkOutput({tag, " prd"}, idx, 32'(prd_out), 32'(pd));
    checkOutput({tag, " prd_old"}, idx, 32'(prd_old_out), 32'(po));
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    // Fields: rv rdv rs1 rs2 rd prf_in alloc chk chkIdx rec recIdx | req ov prs1 prs2 prd prd_old
    // Lane packing is {lane2, lane1, lane0}.
    vecs[0]  = '{3'b001, 3'b001, {5'd0,5'd0,5'd5}, '0, {5'd0,5'd0,5'd3}, {6'd0,6'd0,6'd32},
                 1'b1, 1'b0, 2'd0, 1'b0, 2'd0,
                 3'b001, 3'b001, {6'd0,6'd0,6'd5}, '0, {6'd0,6'd0,6'd32}, {6'd0,6'd0,6'd3}};
    vecs[1]  = '{3'b111, 3'b011, {5'd0,5'd4,5'd3}, {5'd4,5'd0,5'd0}, {5'd0,5'd4,5'd4}, {6'd0,6'd41,6'd40},
                 1'b1, 1'b0, 2'd0, 1'b0, 2'd0,
                 3'b011, 3'b111, {6'd0,6'd40,6'd32}, {6'd41,6'd0,6'd0}, {6'd0,6'd41,6'd40}, {6'd0,6'd40,6'd4}};
    vecs[2]  = '{3'b111, 3'b001, {5'd3,5'd0,5'd0}, {5'd0,5'd4,5'd0}, {5'd0,5'd0,5'd0}, {6'd0,6'd0,6'd50},
                 1'b1, 1'b0, 2'd0, 1'b0, 2'd0,
                 3'b000, 3'b111, {6'd32,6'd0,6'd0}, {6'd0,6'd41,6'd0}, '0, '0};
    vecs[3]  = '{3'b111, 3'b111, '0, '0, {5'd9,5'd10,5'd11}, {6'd62,6'd61,6'd60},
                 1'b0, 1'b0, 2'd0, 1'b0, 2'd0,
                 3'b111, 3'b000, '0, '0, '0, '0};
    vecs[4]  = '{3'b001, 3'b000, {5'd0,5'd0,5'd11}, {5'd0,5'd0,5'd4}, '0, '0,
                 1'b1, 1'b0, 2'd0, 1'b0, 2'd0,
                 3'b000, 3'b001, {6'd0,6'd0,6'd11}, {6'd0,6'd0,6'd41}, '0, '0};
    vecs[5]  = '{3'b111, 3'b111, {5'd12,5'd12,5'd0}, '0, {5'd12,5'd12,5'd12}, {6'd44,6'd43,6'd42},
                 1'b1, 1'b0, 2'd0, 1'b0, 2'd0,
                 3'b111, 3'b111, {6'd43,6'd42,6'd0}, '0, {6'd44,6'd43,6'd42}, {6'd43,6'd42,6'd12}};
    vecs[6]  = '{3'b001, 3'b001, {5'd0,5'd0,5'd12}, {5'd0,5'd0,5'd7}, {5'd0,5'd0,5'd7}, {6'd0,6'd0,6'd33},
                 1'b1, 1'b1, 2'd0, 1'b0, 2'd0,
                 3'b001, 3'b001, {6'd0,6'd0,6'd44}, {6'd0,6'd0,6'd7}, {6'd0,6'd0,6'd33}, {6'd0,6'd0,6'd7}};
    vecs[7]  = '{3'b011, 3'b011, {5'd0,5'd7,5'd0}, '0, {5'd0,5'd8,5'd7}, {6'd0,6'd35,6'd34},
                 1'b1, 1'b0, 2'd0, 1'b0, 2'd0,
                 3'b011, 3'b011, {6'd0,6'd34,6'd0}, '0, {6'd0,6'd35,6'd34}, {6'd0,6'd8,6'd33}};
    vecs[8]  = '{3'b111, 3'b111, '0, '0, {5'd12,5'd3,5'd8}, {6'd52,6'd51,6'd50},
                 1'b1, 1'b1, 2'd1, 1'b1, 2'd0,
                 3'b000, 3'b000, '0, '0, '0, '0};
    vecs[9]  = '{3'b111, 3'b000, {5'd4,5'd12,5'd7}, {5'd0,5'd3,5'd8}, '0, '0,
                 1'b1, 1'b0, 2'd0, 1'b0, 2'd0,
                 3'b000, 3'b111, {6'd41,6'd44,6'd33}, {6'd0,6'd32,6'd8}, '0, '0};
    vecs[10] = '{3'b000, 3'b000, '0, '0, '0, '0,
                 1'b1, 1'b0, 2'd0, 1'b1, 2'd1,
                 3'b000, 3'b000, '0, '0, '0, '0};
    vecs[11] = '{3'b011, 3'b000, {5'd0,5'd4,5'd7}, {5'd0,5'd0,5'd12}, '0, '0,
                 1'b1, 1'b0, 2'd0, 1'b0, 2'd0,
                 3'b000, 3'b011, {6'd0,6'd4,6'd7}, {6'd0,6'd0,6'd12}, '0, '0};
    vecs[12] = '{3'b001, 3'b001, '0, '0, {5'd0,5'd0,5'd5}, {6'd0,6'd0,6'd45},
                 1'b1, 1'b1, 2'd2, 1'b0, 2'd0,
                 3'b001, 3'b001, '0, '0, {6'd0,6'd0,6'd45}, {6'd0,6'd0,6'd5}};
    vecs[13] = '{3'b001, 3'b001, '0, '0, {5'd0,5'd0,5'd5}, {6'd0,6'd0,6'd46},
                 1'b1, 1'b0, 2'd0, 1'b1, 2'd2,
                 3'b000, 3'b000, '0, '0, '0, '0};
    vecs[14] = '{3'b001, 3'b000, {5'd0,5'd0,5'd5}, '0, '0, '0,
                 1'b1, 1'b0, 2'd0, 1'b0, 2'd0,
                 3'b000, 3'b001, {6'd0,6'd0,6'd45}, '0, '0, '0};

    idleInputs();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checkRegs("reset", -1, 3'b000, '0, '0, '0, '0);
    reset = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clock);
      applyStimulus(vecs[i]);
      #1;
      checkOutput("prf_req", i, 32'(prf_req), 32'(vecs[i].expReq));
      @(posedge clock);
      #1;
      checkRegs("vec", i, vecs[i].expOv, vecs[i].expPrs1, vecs[i].expPrs2,
                vecs[i].expPrd, vecs[i].expPrdOld);
    end

    // Asynchronous reset mid-cycle: outputs clear without waiting for an edge.
    #2;
    reset = 1'b0;
    #1;
    checkRegs("async reset", 100, 3'b000, '0, '0, '0, '0);
    @(negedge clock);
    idleInputs();
    reset = 1'b1;
    @(negedge clock);
    rename_valid = 3'b011;
    rs1 = {5'd0, 5'd12, 5'd5};
    rs2 = {5'd0, 5'd4, 5'd7};
    @(posedge clock);
    #1;
    checkRegs("post-reset identity", 101, 3'b011, {6'd0,6'd12,6'd5}, {6'd0,6'd4,6'd7}, '0, '0);

    @(negedge clock);
    idleInputs();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/rat_int.md
# rat_int

Integer register alias table (rename map) for the rename stage. It sits directly downstream of `freelist_int`: it consumes the free list's `prf_out` and `allocatable`, translates up to `RENAME_WIDTH` instructions per cycle from architectural to physical registers, and reports each lane's displaced mapping (`prd_old_out`). That displaced mapping travels through the ROB and returns to the free list as `prf_replace` at commit. The table keeps `2**CP_INDEX_SIZE` checkpoints, driven by the same `check`/`recover` controls as the free list, so that branch recovery restores both structures in the same cycle.

## Interface
- `RENAME_WIDTH`, 3, instructions renamed per cycle
- `ARF_INDEX_SIZE`, 5, architectural register index width (32 regs)
- `PRF_INT_INDEX_SIZE`, 6, physical register index width (64 regs)
- `CP_INDEX_SIZE`, 2, checkpoint index width (4 checkpoints)

Ports:
- `clock` in 1: the single clock; all state updates on the rising edge
- `reset` in 1: asynchronous, active-low
- `rename_valid` in RW: lane holds a valid instruction
- `rd_valid` in RW: lane writes an integer rd
- `rs1`, `rs2`, `rd` in RW×ARF: architectural indices
- `prf_in` in RW×PRF: lane-aligned new physical regs from `freelist_int.prf_out`
- `allocatable` in 1: from the free list
- `check` in 1, `check_idx` in CP: take a checkpoint
- `recover` in 1, `recover_idx` in CP: restore a checkpoint
- `prf_req` out RW: combinational allocation request to the free list
- `prs1_out`, `prs2_out`, `prd_out`, `prd_old_out` out RW×PRF: registered rename results
- `out_valid` out RW: registered lane valid

## Operation
- **State:** `map[32]` of PRF indices, plus `cp[4][32]`.
- **Reset (asserted low):**
  - `map[i]=i` for every register; every `cp[k]` is also the identity map.
  - All outputs are 0.
- **Allocation request:**
  - `prf_req[i] = rename_valid[i] & rd_valid[i] & (rd[i]!=0) & ~recover`.
  - This is purely combinational and does not depend on `allocatable`.
- **Fire condition:** `fire = allocatable & ~recover`. When `fire=0`, `map` is unchanged and `out_valid` is 0 on the next cycle.
- **Lane writes:** lane i writes when `w[i] = fire & prf_req[i]`.
- **Source lookup, lane i:**
  - The result is `map[rs]`, overridden by the highest lane j<i with `w[j]` and `rd[j]==rs`.
  - `rs==0` always yields 0.
- **Destination, lane i:**
  - If `w[i]`: `prd_out=prf_in[i]`, and `prd_old_out` is found by the same lookup rule applied to `rd[i]`.
  - Otherwise `prd_out=0` and `prd_old_out=0`.
- **Map update:** `map[rd[i]] <= prf_in[i]` for each `w[i]`. When several lanes share an rd, the highest lane wins.
- **Lane-valid output:** `out_valid <= fire ? rename_valid : 0`.
- **Checkpoint (`check` with `~recover`):** `cp[check_idx]` receives the map after this cycle's updates.
- **Recover:**
  - `map <= cp[recover_idx]`.
  - Recover has priority over everything: all renames in that cycle are dropped and `check` is ignored.
  - Checkpoint contents are unchanged.
- A lane with `rename_valid=0` never writes, even if `rd_valid=1`.

## Timing
- **Latency:** inputs are sampled at edge N; outputs and map are valid after edge N. Results are therefore one cycle after presentation.
- **Throughput:** `RENAME_WIDTH` lanes per cycle with no bubbles while `allocatable=1`.
- **Pairing with the free list:** `prf_in` is consumed in the same cycle as `prf_req`. The free list pops exactly the lanes with `prf_req & allocatable`.
- **Stall:** `allocatable=0` causes `out_valid=0` on the next edge. The upstream stage must hold its instructions.
- **Recover in cycle N:** lookups in cycle N+1 use the restored map, and `out_valid=0` after edge N.
- **Back-to-back check then recover** of the same index restores exactly the map taken at the check.
- **Reset mid-operation:** the map returns to identity immediately (asynchronous) and `out_valid` clears.

## Test plan
- **Reset, then one lane:** reset low then high; lane0 `rs1=5 rs2=0 rd=3 prf_in=32` → next cycle `prs1=5`, `prs2=0`, `prd=32`, `prd_old=3`, `out_valid=001`.
- **Intra-group bypass:**
  - Stimulus: lane0 `rd=4 prf_in=40`; lane1 `rs1=4 rd=4 prf_in=41`; lane2 `rs2=4`, no rd.
  - Required: lane1 `prs1=40`, `prd_old=40`; lane2 `prs2=41`; `map[4]=41`; `prf_req=011`.
- **x0 handling:** rd=0 with `rd_valid=1` → `prf_req` bit 0, `prd_out=0`, map unchanged; `rs=0` reads 0 even after a bypass candidate.
- **Stall:** `allocatable=0` with `rename_valid=111` → `out_valid=000`, map unchanged; `prf_req` still asserted for the writing lanes.
- **Checkpoint/recover:**
  - Rename r7→33 together with `check=1, check_idx=0`.
  - Rename r7→34 and r8→35.
  - `recover=1, recover_idx=0` → `map[7]=33`, `map[8]=8`, `out_valid=0`, `prf_req=000` during the recover cycle.
- **Recover priority:** `recover` and `check` in the same cycle, with renames pending → no map writes, checkpoint `check_idx` unchanged, map equal to `cp[recover_idx]`.
